mem_window_sad: RTL

- Consumer stage directly downstream of the 256x8 byte data memory. The memory is combinational-read, is addressed by an 8-bit Address, and stores a 16x16 frame in row-major order.
- Scans every 4x4 window of the frame and computes the sum of absolute differences (SAD) against a 4x4 template latched at start.
- Reports the minimum SAD and the row/column of the window that produced it.
- Drives the memory's Address and MemRead and samples its ReadData. Never writes memory.

---
 rtl/mem_window_sad_pkg.sv | 23 ++
 rtl/sad_addr_gen.sv | 81 ++++++++
 rtl/mem_window_sad.sv | 130 +++++++++++++
 3 files changed

// File: rtl/mem_window_sad_pkg.sv
// Shared types and constants for the windowed SAD scanner.
// Scans every WINxWIN window of a row-major frame held in a combinational-read byte memory.
package mem_window_sad_pkg;
  localparam int FRAME_W_DEF = 16;
  localparam int WIN_DEF     = 4;
  localparam int ADDR_W_DEF  = 8;
  localparam int SAD_W_DEF   = 12;

  localparam int NPOS        = FRAME_W_DEF - WIN_DEF + 1;
  localparam int NTAP        = WIN_DEF * WIN_DEF;
  localparam int CYC_PER_WIN = NTAP + 1;

  localparam logic [SAD_W_DEF-1:0] SAD_MAX = '1;

  typedef enum logic [1:0] {IDLE, READ, CMP, DONE} state_t;

  // Magnitude of the 9-bit unsigned difference a - b.
  function automatic logic [7:0] absdiff8(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] d;
    d = {1'b0, a} - {1'b0, b};
    return d[8] ? 8'(-d) : d[7:0];
  endfunction
endpackage

// File: rtl/sad_addr_gen.sv
// Window/tap counters for the SAD scanner.
// Emits the frame address of the current tap and the end-of-window / end-of-frame flags.
module sad_addr_gen #(
  parameter int FRAME_W = 16,
  parameter int WIN     = 4,
  parameter int ADDR_W  = 8,
  localparam int RC_W   = $clog2(FRAME_W),
  localparam int K_W    = $clog2(WIN),
  localparam int T_W    = $clog2(WIN*WIN)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clear_i,
  input  logic              tap_adv_i,
  input  logic              win_adv_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic [T_W-1:0]    tap_o,
  output logic              last_tap_o,
  output logic              last_win_o,
  output logic [RC_W-1:0]   row_o,
  output logic [RC_W-1:0]   col_o
);
  localparam logic [RC_W-1:0] LAST_POS = RC_W'(FRAME_W - WIN);
  localparam logic [K_W-1:0]  LAST_K   = K_W'(WIN - 1);

  logic [RC_W-1:0]   row_q, col_q, row_d, col_d;
  logic [K_W-1:0]    wr_q, wc_q, wr_d, wc_d;
  logic [ADDR_W-1:0] y, x;

  assign last_tap_o = (wr_q == LAST_K) && (wc_q == LAST_K);
  assign last_win_o = (row_q == LAST_POS) && (col_q == LAST_POS);
  assign row_o      = row_q;
  assign col_o      = col_q;

  // Row-major address; the result wraps to ADDR_W bits.
  assign y      = ADDR_W'(row_q) + ADDR_W'(wr_q);
  assign x      = ADDR_W'(col_q) + ADDR_W'(wc_q);
  assign addr_o = y * ADDR_W'(FRAME_W) + x;
  assign tap_o  = T_W'(int'(wr_q) * WIN + int'(wc_q));

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    wr_d  = wr_q;
    wc_d  = wc_q;
    if (clear_i) begin
      row_d = '0;
      col_d = '0;
      wr_d  = '0;
      wc_d  = '0;
    end else if (tap_adv_i) begin
      if (wc_q == LAST_K) begin
        wc_d = '0;
        wr_d = (wr_q == LAST_K) ? '0 : wr_q + 1'b1;
      end else begin
        wc_d = wc_q + 1'b1;
      end
    end else if (win_adv_i) begin
      if (col_q == LAST_POS) begin
        col_d = '0;
        row_d = last_win_o ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      row_q <= '0;
      col_q <= '0;
      wr_q  <= '0;
      wc_q  <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
      wr_q  <= wr_d;
      wc_q  <= wc_d;
    end
  end
endmodule

// File: rtl/mem_window_sad.sv
// Minimum-SAD template search over a frame held in the upstream byte memory.
// One read per cycle, one compare cycle per window, one-cycle Done pulse with registered result.
module mem_window_sad
  import mem_window_sad_pkg::*;
#(
  parameter int FRAME_W = FRAME_W_DEF,
  parameter int WIN     = WIN_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int SAD_W   = SAD_W_DEF,
  localparam int NT     = WIN * WIN,
  localparam int RC_W   = $clog2(FRAME_W),
  localparam int T_W    = $clog2(NT)
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Start,
  input  logic [NT*8-1:0]   Template,
  output logic [ADDR_W-1:0] MemAddr,
  output logic              MemRead,
  input  logic [7:0]        ReadData,
  output logic              Busy,
  output logic              Done,
  output logic [SAD_W-1:0]  MinSAD,
  output logic [RC_W-1:0]   MinRow,
  output logic [RC_W-1:0]   MinCol
);
  state_t state_q, state_d;
  logic   start_scan, tap_adv, win_adv;

  logic [NT*8-1:0]   tpl_q;
  logic [SAD_W-1:0]  acc_q, best_q, min_sad_q;
  logic [RC_W-1:0]   brow_q, bcol_q, min_row_q, min_col_q;
  logic [ADDR_W-1:0] addr, addr_hold_q;
  logic [T_W-1:0]    tap;
  logic              last_tap, last_win, better;
  logic [RC_W-1:0]   row, col;
  logic [7:0]        tpl_byte;

  sad_addr_gen #(.FRAME_W(FRAME_W), .WIN(WIN), .ADDR_W(ADDR_W)) u_addr (
    .clk_i     (Clk),
    .rst_i     (Rst),
    .clear_i   (start_scan),
    .tap_adv_i (tap_adv),
    .win_adv_i (win_adv),
    .addr_o    (addr),
    .tap_o     (tap),
    .last_tap_o(last_tap),
    .last_win_o(last_win),
    .row_o     (row),
    .col_o     (col)
  );

  always_comb begin
    state_d    = state_q;
    start_scan = 1'b0;
    tap_adv    = 1'b0;
    win_adv    = 1'b0;
    unique case (state_q)
      IDLE: if (Start) begin
        start_scan = 1'b1;
        state_d    = READ;
      end
      READ: begin
        tap_adv = 1'b1;
        if (last_tap) state_d = CMP;
      end
      CMP: begin
        win_adv = 1'b1;
        state_d = last_win ? DONE : READ;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  assign tpl_byte = tpl_q[8*int'(tap) +: 8];
  // Strict compare so ties keep the earlier window in raster order.
  assign better   = acc_q < best_q;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      tpl_q       <= '0;
      acc_q       <= '0;
      best_q      <= '1;
      brow_q      <= '0;
      bcol_q      <= '0;
      min_sad_q   <= '0;
      min_row_q   <= '0;
      min_col_q   <= '0;
      addr_hold_q <= '0;
    end else begin
      if (start_scan) begin
        tpl_q  <= Template;
        acc_q  <= '0;
        best_q <= '1;
      end
      if (tap_adv) begin
        acc_q       <= acc_q + SAD_W'(absdiff8(ReadData, tpl_byte));
        addr_hold_q <= addr;
      end
      if (win_adv) begin
        acc_q <= '0;
        if (better) begin
          best_q <= acc_q;
          brow_q <= row;
          bcol_q <= col;
        end
        // Result registers load on the final compare so they are valid during DONE.
        if (last_win) begin
          min_sad_q <= better ? acc_q : best_q;
          min_row_q <= better ? row   : brow_q;
          min_col_q <= better ? col   : bcol_q;
        end
      end
    end
  end

  assign MemRead = (state_q == READ);
  assign MemAddr = MemRead ? addr : addr_hold_q;
  assign Busy    = (state_q != IDLE);
  assign Done    = (state_q == DONE);
  assign MinSAD  = min_sad_q;
  assign MinRow  = min_row_q;
  assign MinCol  = min_col_q;
endmodule
